// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-requester arbiter/sequencer for the single-port data RAM
//
// Requester 0 is the CPU data port, requester 1 the DMA/debug loader.
// Each access runs IDLE -> ACCESS -> DONE (or IDLE -> DONE for a bad address).
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN        requester N request (level, held until ackN) and payload
//   ackN, errN, rdataN              requester N one-cycle completion, address error, read data
//   gnt                             one-hot current owner, 0 when idle
//   busy                            high while an access is in ACCESS or DONE
//   ram_addr, ram_w_r, ram_wr_data  RAM bus; parked at address 0, read, when not in ACCESS
//   ram_rd_data                     RAM read data, updated by the RAM on the falling edge

module ram_arbiter #(
    parameter int DEPTH = 100,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_w_r,
    output logic [DW-1:0] ram_wr_data,
    input  logic [DW-1:0] ram_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;      // index of the most recently granted requester
    logic [1:0]    r_gnt;
    logic          r_busy;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_w_r;
    logic [DW-1:0] r_ram_wr_data;

    logic          w_any;
    logic          w_sel1;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_in_range;

    // Requester 1 wins when it is alone, or when both ask and requester 0 went last.
    assign w_any      = req0 | req1;
    assign w_sel1     = req1 & (~req0 | ~r_last);
    assign w_we       = w_sel1 ? we1    : we0;
    assign w_addr     = w_sel1 ? addr1  : addr0;
    assign w_wdata    = w_sel1 ? wdata1 : wdata0;
    assign w_in_range = w_addr < AW'(DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_gnt         <= 2'b00;
            r_busy        <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_err0        <= 1'b0;
            r_err1        <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_ram_addr    <= '0;
            r_ram_w_r     <= 1'b0;
            r_ram_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_sel1 ? 2'b10 : 2'b01;
                        r_last <= w_sel1;
                        r_busy <= 1'b1;
                        if (w_in_range) begin
                            r_ram_addr    <= w_addr;
                            r_ram_w_r     <= w_we;
                            r_ram_wr_data <= w_wdata;
                            r_state       <= S_ACCESS;
                        end else begin
                            // Bad address: the RAM bus stays parked, complete with an error.
                            if (w_sel1) begin
                                r_ack1   <= 1'b1;
                                r_err1   <= 1'b1;
                                r_rdata1 <= '0;
                            end else begin
                                r_ack0   <= 1'b1;
                                r_err0   <= 1'b1;
                                r_rdata0 <= '0;
                            end
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ACCESS: begin
                    // RAM sampled the bus on the falling edge; read data is valid now.
                    if (r_gnt[1]) begin
                        r_ack1 <= 1'b1;
                        if (!r_ram_w_r) r_rdata1 <= ram_rd_data;
                    end else begin
                        r_ack0 <= 1'b1;
                        if (!r_ram_w_r) r_rdata0 <= ram_rd_data;
                    end
                    r_ram_addr <= '0;
                    r_ram_w_r  <= 1'b0;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign err0        = r_err0;
    assign err1        = r_err1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign ram_addr    = r_ram_addr;
    assign ram_w_r     = r_ram_w_r;
    assign ram_wr_data = r_ram_wr_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter

module tb_ram_arbiter;

    localparam int DEPTH = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we  = 2'b00;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    logic        ack0, ack1, err0, err1, busy, ram_w_r;
    logic [31:0] rdata0, rdata1, ram_addr, ram_wr_data;
    logic [31:0] ram_rd_data = 32'h0;
    logic [1:0]  gnt;

    wire [1:0] ackv = {ack1, ack0};
    wire [1:0] errv = {err1, err0};

    int checks = 0;
    int errors = 0;

    logic [31:0] shadow [DEPTH];

    ram_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .gnt(gnt), .busy(busy),
        .ram_addr(ram_addr), .ram_w_r(ram_w_r), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Environment RAM: samples on the falling edge, preloaded with word i = i*0x11.
    logic [31:0] ram_mem [DEPTH];
    bit          loaded = 1'b0;
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 32'(i * 17);
            loaded <= 1'b1;
        end else if (ram_addr < DEPTH) begin
            if (ram_w_r) ram_mem[ram_addr] <= ram_wr_data;
            ram_rd_data <= ram_mem[ram_addr];
        end else begin
            ram_rd_data <= 32'h0;
        end
    end

    // Cycle-by-cycle protocol rules.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ((ack0 && ack1) || (err0 && !ack0) || (err1 && !ack1) ||
                (ram_w_r && (!busy || ack0 || ack1 || ram_addr >= DEPTH))) begin
                errors++;
                $display("FAIL monitor t=%0t ack=%b err=%b busy=%b ram_w_r=%b ram_addr=%h",
                         $time, ackv, errv, busy, ram_w_r, ram_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int n);
        return (n == 1) ? rdata1 : rdata0;
    endfunction

    task automatic set_req(input int n, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[n]   = 1'b1;
        we[n]    = w;
        addr[n]  = a;
        wdata[n] = d;
    endtask

    task automatic wait_ack(input int n, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (ackv[n]) got = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int          who;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic logic [31:0] new_addr();
        int r = $urandom_range(15, 0);
        if (r == 0) return 32'(100 + $urandom_range(2, 0));
        if (r == 1) return 32'hFFFF_FFFF;
        return 32'($urandom_range(DEPTH - 1, 0));
    endfunction

    initial begin
        vec_t        vecs [$];
        bit          got;
        int          cyc;
        int          owners [$];
        int          times  [$];
        logic [31:0] vals   [$];
        int          tnow;
        int          expect_next;
        int          age [2];
        logic [31:0] last_rd [2];

        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'(i * 17);
        for (int n = 0; n < 2; n++) begin
            addr[n] = 32'h0;
            wdata[n] = 32'h0;
        end

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_gnt", {30'h0, gnt}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_ack", {30'h0, ackv}, 0);
        chk("rst_err", {30'h0, errv}, 0);
        chk("rst_ram_w_r", {31'h0, ram_w_r}, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wr_data", ram_wr_data, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);

        // Single write, cycle by cycle
        set_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_access_gnt", {30'h0, gnt}, 32'h1);
        chk("wr_access_busy", {31'h0, busy}, 1);
        chk("wr_access_w_r", {31'h0, ram_w_r}, 1);
        chk("wr_access_addr", ram_addr, 5);
        chk("wr_access_data", ram_wr_data, 32'hDEAD_BEEF);
        chk("wr_access_noack", {30'h0, ackv}, 0);
        @(negedge clk);
        chk("wr_done_ack0", {30'h0, ackv}, 32'h1);
        chk("wr_done_err0", {31'h0, err0}, 0);
        chk("wr_done_w_r", {31'h0, ram_w_r}, 0);
        chk("wr_done_addr", ram_addr, 0);
        chk("wr_done_gnt", {30'h0, gnt}, 32'h1);
        req[0] = 1'b0;
        shadow[5] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_idle_gnt", {30'h0, gnt}, 0);
        chk("wr_idle_busy", {31'h0, busy}, 0);
        chk("wr_idle_ack", {30'h0, ackv}, 0);

        // Single-transaction table
        vecs.push_back('{0, 1'b0, 32'd5,          32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{1, 1'b1, 32'd99,         32'hCAFE_0099, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'd99,         32'h0,         1'b0, 1'b1, 32'hCAFE_0099});
        vecs.push_back('{1, 1'b1, 32'd100,        32'h1111_1111, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'd99,         32'h0,         1'b0, 1'b1, 32'hCAFE_0099});
        vecs.push_back('{1, 1'b1, 32'hFFFF_FFFF,  32'h2222_2222, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'd99,         32'h0,         1'b0, 1'b1, 32'hCAFE_0099});
        vecs.push_back('{1, 1'b1, 32'd50,         32'h5050_5050, 1'b0, 1'b1, 32'hCAFE_0099});
        vecs.push_back('{0, 1'b0, 32'd0,          32'h0,         1'b0, 1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'd100,        32'h0,         1'b1, 1'b1, 32'h0});
        vecs.push_back('{0, 1'b1, 32'd99,         32'h1234_5678, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'd99,         32'h0,         1'b0, 1'b1, 32'h1234_5678});
        vecs.push_back('{1, 1'b0, 32'd50,         32'h0,         1'b0, 1'b1, 32'h5050_5050});
        foreach (vecs[i]) begin
            set_req(vecs[i].who, vecs[i].w, vecs[i].a, vecs[i].d);
            wait_ack(vecs[i].who, got, cyc);
            chk($sformatf("vec%0d_ack", i), {31'h0, got}, 1);
            if (got) begin
                if (!vecs[i].exp_err) chk($sformatf("vec%0d_latency", i), cyc, 2);
                chk($sformatf("vec%0d_other_ack", i), {31'h0, ackv[1 - vecs[i].who]}, 0);
                chk($sformatf("vec%0d_err", i), {31'h0, errv[vecs[i].who]}, {31'h0, vecs[i].exp_err});
                if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd(vecs[i].who), vecs[i].exp_rd);
                if (vecs[i].w && !vecs[i].exp_err) shadow[vecs[i].a] = vecs[i].d;
            end
            req[vecs[i].who] = 1'b0;
            @(negedge clk);
        end

        // Continuous contention from reset: grants 0,1,0,1 spaced 3 cycles
        do_reset();
        set_req(0, 1'b0, 32'd1, 32'h0);
        set_req(1, 1'b0, 32'd2, 32'h0);
        tnow = 0;
        while (owners.size() < 4 && tnow < 30) begin
            @(negedge clk);
            tnow++;
            for (int n = 0; n < 2; n++) begin
                if (ackv[n]) begin
                    owners.push_back(n);
                    times.push_back(tnow);
                    vals.push_back(rd(n));
                end
            end
        end
        req = 2'b00;
        chk("cont_ack_count", owners.size(), 4);
        for (int i = 0; i < owners.size(); i++) begin
            chk($sformatf("cont_owner%0d", i), owners[i], i % 2);
            chk($sformatf("cont_rdata%0d", i), vals[i], (i % 2 == 0) ? 32'h11 : 32'h22);
            if (i > 0) chk($sformatf("cont_spacing%0d", i), times[i] - times[i - 1], 3);
        end
        @(negedge clk);

        // Waiting requester changes its address before its own grant
        set_req(0, 1'b0, 32'd3, 32'h0);
        set_req(1, 1'b0, 32'd7, 32'h0);
        @(negedge clk);
        addr[1] = 32'd8;
        wait_ack(0, got, cyc);
        chk("chg_ack0", {31'h0, got}, 1);
        chk("chg_rdata0", rdata0, shadow[3]);
        req[0] = 1'b0;
        wait_ack(1, got, cyc);
        chk("chg_ack1", {31'h0, got}, 1);
        chk("chg_rdata1", rdata1, shadow[8]);
        req[1] = 1'b0;
        @(negedge clk);

        // Reset during a write's ACCESS cycle, before the RAM samples it
        set_req(0, 1'b1, 32'd10, 32'hBAD0_BAD0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", {30'h0, gnt}, 0);
        chk("mid_rst_busy", {31'h0, busy}, 0);
        chk("mid_rst_w_r", {31'h0, ram_w_r}, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_wdata", ram_wr_data, 0);
        chk("mid_rst_rdata0", rdata0, 0);
        req[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_noack", {30'h0, ackv}, 0);
        end
        rst = 1'b1;
        set_req(0, 1'b0, 32'd10, 32'h0);
        set_req(1, 1'b0, 32'd11, 32'h0);
        wait_ack(0, got, cyc);
        chk("post_rst_first_r0", {31'h0, got}, 1);
        chk("post_rst_ack1_low", {31'h0, ack1}, 0);
        chk("post_rst_rdata0", rdata0, shadow[10]);
        req[0] = 1'b0;
        wait_ack(1, got, cyc);
        chk("post_rst_ack1", {31'h0, got}, 1);
        chk("post_rst_rdata1", rdata1, shadow[11]);
        req[1] = 1'b0;
        @(negedge clk);

        // Idle parking
        repeat (10) begin
            @(negedge clk);
            chk("park_gnt", {30'h0, gnt}, 0);
            chk("park_busy", {31'h0, busy}, 0);
            chk("park_w_r", {31'h0, ram_w_r}, 0);
            chk("park_addr", ram_addr, 0);
        end

        // Randomized traffic against a transaction-level model
        do_reset();
        expect_next = -1;
        for (int n = 0; n < 2; n++) begin
            age[n] = 0;
            last_rd[n] = 32'h0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (ackv[n]) begin
                    logic        e;
                    logic [31:0] exp;
                    e = addr[n] >= DEPTH;
                    chk("rnd_req_held", {31'h0, req[n]}, 1);
                    chk("rnd_latency", {31'h0, age[n] <= 5}, 1);
                    if (expect_next >= 0) chk("rnd_rr_order", n, expect_next);
                    chk("rnd_err", {31'h0, errv[n]}, {31'h0, e});
                    if (e) exp = 32'h0;
                    else if (we[n]) exp = last_rd[n];
                    else exp = shadow[addr[n]];
                    chk("rnd_rdata", rd(n), exp);
                    last_rd[n] = exp;
                    if (!e && we[n]) shadow[addr[n]] = wdata[n];
                    expect_next = req[1 - n] ? 1 - n : -1;
                    age[n] = 0;
                    if ($urandom_range(1, 0) == 1) set_req(n, 1'($urandom_range(1, 0)), new_addr(), $urandom);
                    else req[n] = 1'b0;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (req[n] && !ackv[n]) begin
                    age[n]++;
                    if (age[n] > 10) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_timeout: requester %0d waited %0d cycles", n, age[n]);
                        req[n] = 1'b0;
                        age[n] = 0;
                        expect_next = -1;
                    end
                end else if (!req[n] && $urandom_range(2, 0) == 0) begin
                    set_req(n, 1'($urandom_range(1, 0)), new_addr(), $urandom);
                    age[n] = 0;
                end
            end
        end
        req = 2'b00;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
